// File: rtl/ro_meas_pkg.sv
// Shared constants for the ring-oscillator frequency measurement block:
// FSM state encodings and default window / counter sizing.
package ro_meas_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_GATE = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int DEF_GATE_CYCLES = 1000;
    localparam int DEF_CNT_W       = 16;
    localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/osc_sync_edge.sv
// Brings the asynchronous oscillator signal into the clk domain and flags
// each synchronised rising edge for one cycle.
module osc_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic osc_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], osc_in};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/ro_freq_counter.sv
// Counts synchronised ring-oscillator rising edges over a fixed window of
// clk cycles and publishes the (saturating) count with a one-cycle valid.
module ro_freq_counter
    import ro_meas_pkg::*;
#(
    parameter int GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             osc_in,
    input  logic             start,
    input  logic             continuous,
    output logic             busy,
    output logic [CNT_W-1:0] count_out,
    output logic             valid,
    output logic             overflow
);

    localparam int GW = $clog2(GATE_CYCLES);
    localparam int AW = $clog2(SYNC_STAGES + 1);
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [AW-1:0] ARM_LAST  = AW'(SYNC_STAGES);

    logic [1:0]       state;
    logic [AW-1:0]    arm_cnt;
    logic [GW-1:0]    gate_cnt;
    logic [CNT_W-1:0] edge_cnt;
    logic             ovf;
    logic             rise;

    osc_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst   (rst),
        .osc_in(osc_in),
        .rise  (rise)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            arm_cnt   <= '0;
            gate_cnt  <= '0;
            edge_cnt  <= '0;
            ovf       <= 1'b0;
            count_out <= '0;
            overflow  <= 1'b0;
            valid     <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    arm_cnt <= '0;
                    if (start || continuous) state <= ST_ARM;
                end
                // ARM lets edges already in the synchroniser drain before counting
                ST_ARM: begin
                    gate_cnt <= '0;
                    edge_cnt <= '0;
                    ovf      <= 1'b0;
                    if (arm_cnt == ARM_LAST) state <= ST_GATE;
                    else arm_cnt <= arm_cnt + 1'b1;
                end
                ST_GATE: begin
                    if (rise) begin
                        if (edge_cnt == {CNT_W{1'b1}}) ovf <= 1'b1;
                        else edge_cnt <= edge_cnt + 1'b1;
                    end
                    if (gate_cnt == GATE_LAST) state <= ST_DONE;
                    else gate_cnt <= gate_cnt + 1'b1;
                end
                ST_DONE: begin
                    count_out <= edge_cnt;
                    overflow  <= ovf;
                    valid     <= 1'b1;
                    arm_cnt   <= '0;
                    state     <= continuous ? ST_ARM : ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

endmodule
